alu_mem_sequencer: RTL and testbench
====================================

Name: alu_mem_sequencer

Overview:
Micro-sequencer that runs one memory-to-memory ALU operation per command. It reads operand A, and optionally operand B, from the 4K x 8 data memory, then drives the combinational ALU. The result is written back to a destination address and a done pulse is raised. It sits between the core control logic and the memory/ALU pair and is the only master of the memory port while busy.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 8, data/operand width
RD_LAT, 1, cycles from mem_re to valid mem_rdata; legal range 1..3
UNARY_OPS, 16'h0000, bit n set means opcode n is unary: skip the B read, alu_b driven 0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  command request, sampled only in IDLE
opcode_in  in  4  ALU opcode for the command
addr_a  in  ADDR_W  operand A address
addr_b  in  ADDR_W  operand B address
addr_d  in  ADDR_W  destination address
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
overrun  out  1  one-cycle pulse: start seen while busy
result_out  out  DATA_W  last result, held
carry  out  1  last carry_out, held
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
alu_a  out  DATA_W  ALU operand A (registered)
alu_b  out  DATA_W  ALU operand B (registered)
alu_opcode  out  4  ALU opcode (registered)
alu_result  in  DATA_W  ALU result
alu_carry  in  1  ALU carry_out

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. Wait counter 0. Any in-flight write is dropped immediately.
- States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WRITE. All outputs registered.
- IDLE: when start=1 at an edge, latch opcode_in/addr_a/addr_b/addr_d and go to RD_A. busy=1 from the next cycle.
- RD_A (1 cycle): mem_re=1, mem_addr=addr_a. Then go to WAIT_A.
- WAIT_A: stays RD_LAT cycles. On the edge ending the last WAIT_A cycle, mem_rdata is captured into the A register.
- After WAIT_A: go to EXEC if UNARY_OPS[opcode]=1, else go to RD_B.
- RD_B / WAIT_B: same as RD_A/WAIT_A, using addr_b and the B register. For unary ops the B register is cleared to 0.
- EXEC (1 cycle): alu_a/alu_b/alu_opcode are stable from the start of the cycle. alu_result and alu_carry are captured into result_out and carry at the end of the cycle.
- WRITE (1 cycle): mem_we=1, mem_addr=addr_d, mem_wdata=result_out. Then go to IDLE with done=1 for exactly one cycle; busy=0 in that cycle.
- A start in the done cycle is accepted (back-to-back operation).
- Latency, counted from the start-sampling edge to the done-high cycle:
  - binary ops: 5+2*RD_LAT cycles (7 at default)
  - unary ops: 4+RD_LAT cycles (5 at default)
- Outside RD_x/WRITE: mem_re=mem_we=0, mem_addr=0, mem_wdata=0. mem_re and mem_we are never high together.
- alu_a/alu_b/alu_opcode hold their values after completion until the next command.
- start while busy: ignored, overrun=1 for one cycle, command registers unchanged.
- Address aliasing (addr_d equal to addr_a and/or addr_b) is legal: all reads complete before the write.
- Changing the command inputs after acceptance has no effect.
- Reset mid-operation: return to IDLE. result_out and carry are cleared to 0. Memory is not written.

Test Plan:
- Reset, then start with opcode 4'h0, a=12'h010 (mem=8'h3C), b=12'h011 (mem=8'h05), d=12'h020. Bench ALU model gives A+B. -> exactly one write of 8'h41 to 12'h020; done in cycle 7; carry=0.
- Carry: A=8'hF0, B=8'h20, opcode 4'h0 -> write 8'h10, carry=1, result_out=8'h10 held after done.
- Unary: UNARY_OPS=16'h0008, opcode 4'h3 -> one read only (mem_re high 1 cycle), alu_b=0, done in cycle 5.
- RD_LAT=3 binary -> done in cycle 11; read data captured exactly 3 cycles after each mem_re.
- start pulsed during WAIT_B -> overrun pulse, original command completes unchanged; a start in the done cycle is accepted and mem_re asserts in the next cycle.
- reset=0 asynchronously during WRITE -> mem_we falls without a clock edge, busy=0, no done, target location unchanged.

Source files
------------

// File: rtl/alu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mem_sequencer
// Purpose  : Runs one memory-to-memory ALU operation per command. Operand A
//            (and operand B unless the opcode is unary) is read from the data
//            memory, the combinational ALU is driven from registered operands,
//            and the result is written back to the destination address,
//            followed by a one-cycle done pulse.
// Ports    : clk, reset (async, active-low)
//            start, opcode_in, addr_a, addr_b, addr_d    - command request
//            busy, done, overrun                         - command status
//            result_out, carry                           - last result, held
//            mem_we, mem_re, mem_addr, mem_wdata,
//            mem_rdata                                   - memory port
//            alu_a, alu_b, alu_opcode, alu_result,
//            alu_carry                                   - ALU port
// Revision : 1.0 - initial release
// ============================================================================
module alu_mem_sequencer #(
    parameter int          ADDR_W    = 12,
    parameter int          DATA_W    = 8,
    parameter int          RD_LAT    = 1,        // legal range 1..3
    parameter logic [15:0] UNARY_OPS = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        opcode_in,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [DATA_W-1:0] result_out,
    output logic              carry,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_A   = 3'd1,
        S_WAIT_A = 3'd2,
        S_RD_B   = 3'd3,
        S_WAIT_B = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    // Value of the wait counter in the final wait cycle, when read data is valid
    localparam logic [1:0] C_WAIT_LAST = 2'(RD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_wait;
    logic [1:0]          w_wait_nxt;
    logic [ADDR_W-1:0]   r_addr_b;
    logic [ADDR_W-1:0]   r_addr_d;

    logic                w_accept;
    logic                w_cap_a;
    logic                w_cap_b;
    logic                w_clr_b;
    logic                w_cap_res;
    logic                w_unary;
    logic                w_mem_re_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_done_nxt;
    logic                w_busy_nxt;
    logic                w_overrun_nxt;

    // The latched opcode doubles as the registered ALU opcode output
    assign w_unary = UNARY_OPS[alu_opcode];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wait  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and next values of the registered outputs. Memory strobes
    // are computed one cycle ahead so they are registered and aligned with
    // the RD_x / WRITE states they belong to.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = 2'd0;
        w_accept        = 1'b0;
        w_cap_a         = 1'b0;
        w_cap_b         = 1'b0;
        w_clr_b         = 1'b0;
        w_cap_res       = 1'b0;
        w_mem_re_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = S_RD_A;
                    w_mem_re_nxt   = 1'b1;
                    // addr_a is consumed here directly, so it needs no latch
                    w_mem_addr_nxt = addr_a;
                end
            end
            S_RD_A: begin
                w_state_nxt = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (r_wait == C_WAIT_LAST) begin
                    w_cap_a = 1'b1;
                    if (w_unary) begin
                        w_clr_b     = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt    = S_RD_B;
                        w_mem_re_nxt   = 1'b1;
                        w_mem_addr_nxt = r_addr_b;
                    end
                end else begin
                    w_wait_nxt = r_wait + 2'd1;
                end
            end
            S_RD_B: begin
                w_state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (r_wait == C_WAIT_LAST) begin
                    w_cap_b     = 1'b1;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_wait_nxt = r_wait + 2'd1;
                end
            end
            S_EXEC: begin
                // The write data is the ALU output captured in this same edge,
                // so it always equals result_out during WRITE.
                w_cap_res       = 1'b1;
                w_state_nxt     = S_WRITE;
                w_mem_we_nxt    = 1'b1;
                w_mem_addr_nxt  = r_addr_d;
                w_mem_wdata_nxt = alu_result;
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_overrun_nxt = start && (r_state != S_IDLE);
    end

    // ------------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            result_out <= '0;
            carry      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 4'd0;
            r_addr_b   <= '0;
            r_addr_d   <= '0;
        end else begin
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            overrun   <= w_overrun_nxt;
            mem_re    <= w_mem_re_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;

            if (w_accept) begin
                alu_opcode <= opcode_in;
                r_addr_b   <= addr_b;
                r_addr_d   <= addr_d;
            end

            if (w_cap_a) begin
                alu_a <= mem_rdata;
            end

            if (w_cap_b) begin
                alu_b <= mem_rdata;
            end else if (w_clr_b) begin
                alu_b <= '0;
            end

            if (w_cap_res) begin
                result_out <= alu_result;
                carry      <= alu_carry;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mem_sequencer
// Purpose  : Self-checking bench for alu_mem_sequencer. Two instances are
//            used: index 0 with RD_LAT=1 and index 1 with RD_LAT=3, both with
//            opcode 3 unary. The bench supplies a latency-accurate memory and
//            a behavioural ALU, and predicts results from memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mem_sequencer;

    localparam logic [15:0] UNARY = 16'h0008;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [3:0]       opcode;
    logic [11:0]      addr_a, addr_b, addr_d;
    logic [1:0]       start_v;
    logic [1:0][7:0]  rdata_v;

    wire  [1:0]       busy_v, done_v, overrun_v, carry_v, we_v, re_v, alu_c_v;
    wire  [1:0][11:0] maddr_v;
    wire  [1:0][7:0]  result_v, wdata_v, alu_a_v, alu_b_v, alu_res_v;
    wire  [1:0][3:0]  alu_op_v;

    logic [7:0] mem [2][4096];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural ALU: returns {carry, result}
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0:    return {1'b0, a} + {1'b0, b};
            4'h1:    return {1'b0, a} - {1'b0, b};
            4'h2:    return {1'b0, a & b};
            4'h3:    return {1'b0, ~a};
            4'h4:    return {1'b0, a ^ b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            alu_mem_sequencer #(
                .ADDR_W    (12),
                .DATA_W    (8),
                .RD_LAT    ((k == 0) ? 1 : 3),
                .UNARY_OPS (UNARY)
            ) u_dut (
                .clk        (clk),
                .reset      (rst_n),
                .start      (start_v[k]),
                .opcode_in  (opcode),
                .addr_a     (addr_a),
                .addr_b     (addr_b),
                .addr_d     (addr_d),
                .busy       (busy_v[k]),
                .done       (done_v[k]),
                .overrun    (overrun_v[k]),
                .result_out (result_v[k]),
                .carry      (carry_v[k]),
                .mem_we     (we_v[k]),
                .mem_re     (re_v[k]),
                .mem_addr   (maddr_v[k]),
                .mem_wdata  (wdata_v[k]),
                .mem_rdata  (rdata_v[k]),
                .alu_a      (alu_a_v[k]),
                .alu_b      (alu_b_v[k]),
                .alu_opcode (alu_op_v[k]),
                .alu_result (alu_res_v[k]),
                .alu_carry  (alu_c_v[k])
            );
            assign {alu_c_v[k], alu_res_v[k]} = alu_f(alu_op_v[k], alu_a_v[k], alu_b_v[k]);
        end
    endgenerate

    // Observations of the most recent command
    int          o_done_cyc, o_re_cnt, o_we_cnt, o_ovr_cnt, o_ovr_cyc, o_busy_err, o_idle_err;
    int          o_re_cyc [2];
    logic [11:0] o_re_addr [2];
    logic [11:0] o_we_addr;
    logic [7:0]  o_we_data, o_result, o_alu_a, o_alu_b;
    logic        o_carry;

    // Expected values of the current command
    int          e_cyc, e_reads;
    logic [8:0]  e_alu;
    logic [7:0]  e_opa, e_opb;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Predict a command from the spec's rules and the current memory image
    task automatic predict(input int k, input logic [3:0] op, input logic [11:0] a, input logic [11:0] b);
        logic [15:0] um;
        logic        un;
        um      = UNARY;
        un      = um[op];
        e_opa   = mem[k][a];
        e_opb   = un ? 8'h00 : mem[k][b];
        e_alu   = alu_f(op, e_opa, e_opb);
        e_cyc   = un ? (4 + lat_of(k)) : (5 + 2 * lat_of(k));
        e_reads = un ? 1 : 2;
    endtask

    // Issue a command and observe it cycle by cycle until done (or timeout).
    // Called and returning at a falling edge; returns in the done cycle.
    task automatic run_cmd(input int k, input logic [3:0] op, input logic [11:0] a,
                           input logic [11:0] b, input logic [11:0] d,
                           input int ov_cyc, input bit scramble);
        int          due_q [$];
        logic [11:0] pa_q  [$];
        o_done_cyc = 0; o_re_cnt = 0; o_we_cnt = 0; o_ovr_cnt = 0; o_ovr_cyc = 0;
        o_busy_err = 0; o_idle_err = 0;
        o_re_cyc[0] = 0; o_re_cyc[1] = 0; o_re_addr[0] = '0; o_re_addr[1] = '0;
        o_we_addr = '0; o_we_data = '0;
        opcode = op; addr_a = a; addr_b = b; addr_d = d;
        start_v[k] = 1'b1;
        rdata_v[k] = 8'($urandom);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start_v[k] = (n == ov_cyc);
            if (scramble) begin
                opcode = 4'($urandom); addr_a = 12'($urandom);
                addr_b = 12'($urandom); addr_d = 12'($urandom);
            end
            if (overrun_v[k]) begin
                o_ovr_cnt++;
                o_ovr_cyc = n;
            end
            if ((done_v[k] && busy_v[k]) || (!done_v[k] && !busy_v[k])) o_busy_err++;
            if (re_v[k] && we_v[k]) o_idle_err++;
            if (!re_v[k] && !we_v[k] && (maddr_v[k] != 12'h0 || wdata_v[k] != 8'h0)) o_idle_err++;
            if (re_v[k]) begin
                if (o_re_cnt < 2) begin
                    o_re_cyc[o_re_cnt]  = n;
                    o_re_addr[o_re_cnt] = maddr_v[k];
                end
                o_re_cnt++;
                due_q.push_back(n + lat_of(k));
                pa_q.push_back(maddr_v[k]);
            end
            if (we_v[k]) begin
                o_we_cnt++;
                o_we_addr = maddr_v[k];
                o_we_data = wdata_v[k];
                mem[k][maddr_v[k]] = wdata_v[k];
            end
            // Read data is valid only in the cycle exactly RD_LAT after mem_re
            rdata_v[k] = 8'($urandom);
            if (due_q.size() > 0 && due_q[0] == n) begin
                rdata_v[k] = mem[k][pa_q[0]];
                due_q.delete(0);
                pa_q.delete(0);
            end
            if (done_v[k]) begin
                o_done_cyc = n;
                o_result   = result_v[k];
                o_carry    = carry_v[k];
                o_alu_a    = alu_a_v[k];
                o_alu_b    = alu_b_v[k];
                break;
            end
        end
        start_v[k] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; start_v = 2'b00; rdata_v = '0;
        opcode = 4'h0; addr_a = '0; addr_b = '0; addr_d = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) mem[k][i] = 8'($urandom);
        idle_cycles(3);
        n_checks++;
        if ({busy_v, done_v, overrun_v, carry_v, we_v, re_v} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h expected 000", {busy_v, done_v, overrun_v, carry_v, we_v, re_v});
        end
        n_checks++;
        if ({maddr_v, wdata_v, result_v, alu_a_v, alu_b_v, alu_op_v} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {maddr_v, wdata_v, result_v, alu_a_v, alu_b_v, alu_op_v});
        end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_add_basic();
        mem[0][12'h010] = 8'h3C; mem[0][12'h011] = 8'h05;
        run_cmd(0, 4'h0, 12'h010, 12'h011, 12'h020, 0, 1'b0);
        n_checks++;
        if (o_done_cyc !== 7) begin n_fail++; $display("FAIL add_latency: got %0d expected 7", o_done_cyc); end
        n_checks++;
        if (o_we_cnt !== 1 || o_we_addr !== 12'h020 || o_we_data !== 8'h41) begin
            n_fail++;
            $display("FAIL add_write: got cnt=%0d addr=%h data=%h expected cnt=1 addr=020 data=41", o_we_cnt, o_we_addr, o_we_data);
        end
        n_checks++;
        if (o_carry !== 1'b0 || o_result !== 8'h41) begin
            n_fail++; $display("FAIL add_result: got carry=%b res=%h expected carry=0 res=41", o_carry, o_result);
        end
        n_checks++;
        if (o_re_cnt !== 2 || o_re_addr[0] !== 12'h010 || o_re_addr[1] !== 12'h011 || o_re_cyc[0] !== 1 || o_re_cyc[1] !== 3) begin
            n_fail++;
            $display("FAIL add_reads: got cnt=%0d %h@%0d %h@%0d expected cnt=2 010@1 011@3",
                     o_re_cnt, o_re_addr[0], o_re_cyc[0], o_re_addr[1], o_re_cyc[1]);
        end
        n_checks++;
        if (o_busy_err !== 0 || o_idle_err !== 0 || o_ovr_cnt !== 0) begin
            n_fail++;
            $display("FAIL add_status: got busy_err=%0d port_err=%0d ovr=%0d expected 0 0 0", o_busy_err, o_idle_err, o_ovr_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL add_done_pulse: got done=%b busy=%b expected 0 0", done_v[0], busy_v[0]);
        end
        idle_cycles(1);
    endtask

    task automatic test_carry();
        mem[0][12'h030] = 8'hF0; mem[0][12'h031] = 8'h20;
        run_cmd(0, 4'h0, 12'h030, 12'h031, 12'h032, 0, 1'b0);
        n_checks++;
        if (o_we_data !== 8'h10 || o_carry !== 1'b1 || o_done_cyc !== 7) begin
            n_fail++;
            $display("FAIL carry_op: got data=%h carry=%b cyc=%0d expected 10 1 7", o_we_data, o_carry, o_done_cyc);
        end
        idle_cycles(3);
        n_checks++;
        if (result_v[0] !== 8'h10 || carry_v[0] !== 1'b1 || alu_a_v[0] !== 8'hF0 || alu_b_v[0] !== 8'h20 || alu_op_v[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL carry_hold: got res=%h c=%b a=%h b=%h op=%h expected 10 1 f0 20 0",
                     result_v[0], carry_v[0], alu_a_v[0], alu_b_v[0], alu_op_v[0]);
        end
    endtask

    task automatic test_unary();
        predict(0, 4'h3, 12'h040, 12'h041);
        run_cmd(0, 4'h3, 12'h040, 12'h041, 12'h042, 0, 1'b0);
        n_checks++;
        if (o_done_cyc !== 5 || o_re_cnt !== 1) begin
            n_fail++; $display("FAIL unary_timing: got cyc=%0d reads=%0d expected 5 1", o_done_cyc, o_re_cnt);
        end
        n_checks++;
        if (o_alu_b !== 8'h00 || o_alu_a !== e_opa || o_we_data !== e_alu[7:0] || o_we_addr !== 12'h042) begin
            n_fail++;
            $display("FAIL unary_data: got b=%h a=%h wd=%h wa=%h expected 00 %h %h 042", o_alu_b, o_alu_a, o_we_data, o_we_addr, e_opa, e_alu[7:0]);
        end
        idle_cycles(2);
    endtask

    task automatic test_rd_lat3();
        predict(1, 4'h1, 12'h100, 12'h200);
        run_cmd(1, 4'h1, 12'h100, 12'h200, 12'h300, 0, 1'b0);
        n_checks++;
        if (o_done_cyc !== 11 || o_re_cyc[0] !== 1 || o_re_cyc[1] !== 5) begin
            n_fail++;
            $display("FAIL lat3_timing: got cyc=%0d re@%0d,%0d expected 11 re@1,5", o_done_cyc, o_re_cyc[0], o_re_cyc[1]);
        end
        n_checks++;
        if (o_we_data !== e_alu[7:0] || o_carry !== e_alu[8] || o_we_cnt !== 1 || o_busy_err !== 0) begin
            n_fail++;
            $display("FAIL lat3_result: got wd=%h c=%b wr=%0d be=%0d expected %h %b 1 0", o_we_data, o_carry, o_we_cnt, o_busy_err, e_alu[7:0], e_alu[8]);
        end
        idle_cycles(2);
    endtask

    task automatic test_overrun_back_to_back();
        predict(0, 4'h4, 12'h050, 12'h051);
        run_cmd(0, 4'h4, 12'h050, 12'h051, 12'h052, 4, 1'b1);
        n_checks++;
        if (o_ovr_cnt !== 1 || o_ovr_cyc !== 5) begin
            n_fail++; $display("FAIL overrun_pulse: got cnt=%0d cyc=%0d expected 1 5", o_ovr_cnt, o_ovr_cyc);
        end
        n_checks++;
        if (o_we_data !== e_alu[7:0] || o_we_addr !== 12'h052 || o_done_cyc !== 7 || o_re_addr[1] !== 12'h051) begin
            n_fail++;
            $display("FAIL overrun_cmd: got wd=%h wa=%h cyc=%0d rb=%h expected %h 052 7 051", o_we_data, o_we_addr, o_done_cyc, o_re_addr[1], e_alu[7:0]);
        end
        // Issued in the done cycle of the previous command
        predict(0, 4'h2, 12'h060, 12'h061);
        run_cmd(0, 4'h2, 12'h060, 12'h061, 12'h062, 0, 1'b0);
        n_checks++;
        if (o_re_cyc[0] !== 1 || o_re_addr[0] !== 12'h060 || o_done_cyc !== 7 || o_we_data !== e_alu[7:0]) begin
            n_fail++;
            $display("FAIL back_to_back: got re@%0d ra=%h cyc=%0d wd=%h expected re@1 060 7 %h", o_re_cyc[0], o_re_addr[0], o_done_cyc, o_we_data, e_alu[7:0]);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_in_write();
        int  we_seen;
        int  bad;
        opcode = 4'h0; addr_a = 12'h070; addr_b = 12'h071; addr_d = 12'h072;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        we_seen = 0;
        for (int n = 0; n < 20 && we_seen == 0; n++) begin
            if (we_v[0]) we_seen = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (we_seen !== 1) begin n_fail++; $display("FAIL rstw_reach: got we_seen=%0d expected 1", we_seen); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (we_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || result_v[0] !== 8'h00 || carry_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_async: got we=%b busy=%b res=%h c=%b expected 0 0 00 0", we_v[0], busy_v[0], result_v[0], carry_v[0]);
        end
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done_v[0] || we_v[0] || busy_v[0]) bad++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done_v[0] || we_v[0] || busy_v[0] || re_v[0]) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL rstw_quiet: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_random();
        int          k;
        logic [3:0]  op;
        logic [11:0] a, b, d;
        int          errs;
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            k  = i % 2;
            op = 4'($urandom_range(0, 5));
            a  = 12'($urandom_range(0, 15));
            b  = 12'($urandom_range(0, 15));
            d  = 12'($urandom_range(0, 15));
            predict(k, op, a, b);
            run_cmd(k, op, a, b, d, 0, 1'b0);
            if (o_done_cyc != e_cyc || o_re_cnt != e_reads || o_we_cnt != 1 || o_we_addr != d ||
                o_we_data != e_alu[7:0] || o_carry != e_alu[8] || o_busy_err != 0 || o_idle_err != 0) begin
                errs++;
                $display("FAIL random_%0d: got cyc=%0d rd=%0d wr=%0d wa=%h wd=%h c=%b expected %0d %0d 1 %h %h %b",
                         i, o_done_cyc, o_re_cnt, o_we_cnt, o_we_addr, o_we_data, o_carry,
                         e_cyc, e_reads, d, e_alu[7:0], e_alu[8]);
            end
            if (i % 3 == 0) idle_cycles(1);
        end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL random_total: got %0d bad commands expected 0", errs); end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry();
        test_unary();
        test_rd_lat3();
        test_overrun_back_to_back();
        test_reset_in_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
